// File: rtl/axilite_led_regs_pkg.sv
// Shared register offsets, response codes and LED control layout for the AXI-lite LED register file.
package axilite_regs_pkg;

    localparam logic [4:0] REG_ID        = 5'h00;
    localparam logic [4:0] REG_SCRATCH   = 5'h04;
    localparam logic [4:0] REG_LED_CTRL  = 5'h08;
    localparam logic [4:0] REG_BLINK_DIV = 5'h0C;
    localparam logic [4:0] REG_CNT_LO    = 5'h10;
    localparam logic [4:0] REG_CNT_HI    = 5'h14;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef struct packed {
        logic       blink_en;
        logic [3:0] led;
    } led_ctrl_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axilite_led_regs_if.sv
// AXI4-Lite slave bus bundle between the AXI-lite bridge (master) and the LED register file (slave).
interface axilite_led_regs_if #(
    parameter int AW = 12
);
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/axilite_led_regs_blink.sv
// Blink divider: phase toggles every max(div,1) cycles; a write to the divider restarts it at phase 0.
module led_blink_gen (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] div,
    input  logic        div_wr,
    output logic        phase
);

    logic [31:0] cnt_q, cnt_d, last;
    logic        phase_q, phase_d;

    always_comb begin
        last    = (div == 32'd0) ? 32'd0 : div - 32'd1;
        cnt_d   = cnt_q + 32'd1;
        phase_d = phase_q;
        if (div_wr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= last) begin
            // >= so a divider shrunk below the running count restarts instead of wrapping 2^32
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/axilite_led_regs.sv
// AXI4-Lite register file: ID, scratch, LED control with hardware blink, optional 64-bit cycle counter.
// Counter present only when AXIL_LED_REGS_CNT_EN is defined.
module axilite_led_regs
    import axilite_regs_pkg::*;
#(
    parameter int          AW        = 12,
    parameter logic [31:0] ID_VALUE  = 32'hACE0_0215,
    parameter logic [31:0] BLINK_RST = 32'd62_500_000
) (
    input  logic              aclk,
    input  logic              areset,
    axilite_led_regs_if.slave s,
    output logic [3:0]        LEDn
);

    logic        awready_q, awready_d, bvalid_q, bvalid_d;
    resp_t       bresp_q, bresp_d, rresp_q, rresp_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] scratch_q, scratch_d, div_q, div_d;
    led_ctrl_t   led_ctrl_q, led_ctrl_d;
    logic [3:0]  ledn_q, ledn_d;
    logic        wr_hs, rd_hs, wr_ok, rd_ok, div_wr, phase;
    logic [4:0]  waddr, raddr;
    logic [31:0] rd_val, cnt_lo, cnt_hi;

    // Ready is a registered pulse; the transfer completes on the cycle it is seen high.
    assign wr_hs = awready_q & s.s_awvalid & s.s_wvalid;
    assign rd_hs = arready_q & s.s_arvalid;
    assign waddr = {s.s_awaddr[4:2], 2'b00};
    assign raddr = {s.s_araddr[4:2], 2'b00};

`ifdef AXIL_LED_REGS_CNT_EN
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;

    always_comb begin
        cnt_d  = cnt_q + 64'd1;
        snap_d = snap_q;
        if (rd_hs && raddr == REG_CNT_LO)
            snap_d = cnt_q[63:32];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign cnt_lo = cnt_q[31:0];
    assign cnt_hi = snap_q;
`else
    assign cnt_lo = '0;
    assign cnt_hi = '0;
`endif

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        case (raddr)
            REG_ID:        rd_val = ID_VALUE;
            REG_SCRATCH:   rd_val = scratch_q;
            REG_LED_CTRL:  rd_val = {27'b0, led_ctrl_q};
            REG_BLINK_DIV: rd_val = div_q;
            REG_CNT_LO:    rd_val = cnt_lo;
            REG_CNT_HI:    rd_val = cnt_hi;
            default:       rd_ok  = 1'b0;
        endcase
    end

    always_comb begin
        scratch_d  = scratch_q;
        led_ctrl_d = led_ctrl_q;
        div_d      = div_q;
        div_wr     = 1'b0;
        wr_ok      = 1'b1;
        case (waddr)
            REG_SCRATCH:   scratch_d = strb_merge(scratch_q, s.s_wdata, s.s_wstrb);
            REG_LED_CTRL:  if (s.s_wstrb[0]) led_ctrl_d = led_ctrl_t'(s.s_wdata[4:0]);
            REG_BLINK_DIV: begin
                div_d  = strb_merge(div_q, s.s_wdata, s.s_wstrb);
                div_wr = wr_hs;
            end
            default:       wr_ok = 1'b0;
        endcase
        if (!wr_hs) begin
            scratch_d  = scratch_q;
            led_ctrl_d = led_ctrl_q;
            div_d      = div_q;
        end
    end

    always_comb begin
        awready_d = s.s_awvalid & s.s_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s.s_bready) begin
            bvalid_d = 1'b0;
        end

        arready_d = s.s_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s.s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    led_blink_gen u_blink (
        .aclk   (aclk),
        .areset (areset),
        .div    (div_q),
        .div_wr (div_wr),
        .phase  (phase)
    );

    assign ledn_d = ~(led_ctrl_q.led & (led_ctrl_q.blink_en ? {4{phase}} : 4'hF));

    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            scratch_q  <= '0;
            led_ctrl_q <= '0;
            div_q      <= BLINK_RST;
            ledn_q     <= 4'hF;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            scratch_q  <= scratch_d;
            led_ctrl_q <= led_ctrl_d;
            div_q      <= div_d;
            ledn_q     <= ledn_d;
        end
    end

    assign s.s_awready = awready_q;
    assign s.s_wready  = awready_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = arready_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;
    assign LEDn        = ledn_q;

endmodule

// File: tb/tb_axilite_led_regs.sv
// Directed + randomized bench for axilite_led_regs against a register-map reference model.
module tb_axilite_led_regs;

    logic       aclk   = 1'b0;
    logic       areset = 1'b1;
    logic [3:0] LEDn;
    int         vectors = 0, miscompares = 0, cyc = 0, wr_cyc = 0;

    axilite_led_regs_if #(.AW(12)) bus ();

    axilite_led_regs #(.AW(12)) dut (
        .aclk   (aclk),
        .areset (areset),
        .s      (bus),
        .LEDn   (LEDn)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // reference model state
    logic [31:0] m_scratch, m_div;
    logic [4:0]  m_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] st);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic void m_reset();
        m_scratch = 32'h0;
        m_div     = 32'd62_500_000;
        m_ctrl    = 5'h0;
    endfunction

    function automatic void m_read(input logic [11:0] a, output logic [31:0] d,
                                   output logic [1:0] r, output bit known);
        d = 32'h0; r = 2'b00; known = 1'b1;
        case (a[4:2])
            3'd0: d = 32'hACE0_0215;
            3'd1: d = m_scratch;
            3'd2: d = {27'b0, m_ctrl};
            3'd3: d = m_div;
            3'd4, 3'd5: begin
`ifdef AXIL_LED_REGS_CNT_EN
                known = 1'b0;
`endif
            end
            default: r = 2'b10;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] d,
                                    input logic [3:0] st, output logic [1:0] r);
        logic [31:0] t;
        r = 2'b00;
        case (a[4:2])
            3'd1: m_scratch = bytes_merge(m_scratch, d, st);
            3'd2: begin
                t      = bytes_merge({27'b0, m_ctrl}, d, st);
                m_ctrl = t[4:0];
            end
            3'd3: m_div = bytes_merge(m_div, d, st);
            default: r = 2'b10;
        endcase
    endfunction

    task automatic write_req(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int w_delay);
        bit ok = 1'b0;
        bus.s_awaddr = a; bus.s_awvalid = 1'b1;
        bus.s_wdata = d; bus.s_wstrb = st; bus.s_wvalid = 1'b0;
        repeat (w_delay) begin
            @(posedge aclk); #1;
            chk("aw_early_ready", bus.s_awready, 1'b0);
        end
        bus.s_wvalid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(posedge aclk); #1;
            ok = bus.s_awready && bus.s_wready;
        end
        chk("aw_handshake", ok, 1'b1);
        @(posedge aclk); #1;
        wr_cyc = cyc;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (bus.s_bvalid) ok = 1'b1;
            else begin @(posedge aclk); #1; end
        end
        chk("b_valid", ok, 1'b1);
        resp = bus.s_bresp;
        bus.s_bready = 1'b1;
        @(posedge aclk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic read_req(input logic [11:0] a);
        bit ok = 1'b0;
        bus.s_araddr = a; bus.s_arvalid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(posedge aclk); #1;
            ok = bus.s_arready;
        end
        chk("ar_handshake", ok, 1'b1);
        @(posedge aclk); #1;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] d, output logic [1:0] resp);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (bus.s_rvalid) ok = 1'b1;
            else begin @(posedge aclk); #1; end
        end
        chk("r_valid", ok, 1'b1);
        d = bus.s_rdata; resp = bus.s_rresp;
        bus.s_rready = 1'b1;
        @(posedge aclk); #1;
        bus.s_rready = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                      input int w_delay, output logic [1:0] resp);
        write_req(a, d, st, w_delay);
        get_b(resp);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        read_req(a);
        get_r(d, resp);
    endtask

    initial begin
        logic [31:0] d, xd, d2;
        logic [1:0]  r, xr, wr_exp;
        logic [11:0] a, a2;
        logic [3:0]  st;
        bit          known;
        int          op, cE;

        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;
        m_reset();

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", bus.s_awready, 1'b0);
        chk("rst_wready", bus.s_wready, 1'b0);
        chk("rst_arready", bus.s_arready, 1'b0);
        chk("rst_bvalid", bus.s_bvalid, 1'b0);
        chk("rst_rvalid", bus.s_rvalid, 1'b0);
        chk("rst_rdata", bus.s_rdata, 32'h0);
        chk("rst_resp", {bus.s_bresp, bus.s_rresp}, 4'h0);
        chk("rst_ledn", LEDn, 4'hF);
        areset = 1'b0;

        rd(12'h000, d, r);
        chk("id_data", d, 32'hACE0_0215);
        chk("id_resp", r, 2'b00);
        rd(12'h008, d, r);
        chk("ledctrl_rst", d, 32'h0);
        rd(12'h00C, d, r);
        chk("blinkdiv_rst", d, 32'd62_500_000);

        // strobed writes, with and without AW leading W
        wr(12'h004, 32'hDEADBEEF, 4'b0101, 0, r);
        chk("scratch_wr_resp", r, 2'b00);
        rd(12'h004, d, r);
        chk("scratch_strb", d, 32'h00AD00EF);
        wr(12'h004, 32'h0, 4'hF, 0, r);
        wr(12'h004, 32'hDEADBEEF, 4'b0101, 1, r);
        rd(12'h004, d, r);
        chk("scratch_aw_first", d, 32'h00AD00EF);
        m_scratch = 32'h00AD00EF;

        // static LEDs, then blinking with period 4
        wr(12'h008, 32'h05, 4'h1, 0, r);
        chk("ledn_static", LEDn, 4'b1010);
        wr(12'h008, 32'h15, 4'h1, 0, r);
        wr(12'h00C, 32'd4, 4'hF, 0, r);
        cE = wr_cyc;
        for (int k = 0; k < 16; k++) begin
            @(posedge aclk); #1;
            chk("ledn_blink", LEDn, (((cyc - 1 - cE) / 4) % 2) ? 4'b1010 : 4'b1111);
        end
        m_ctrl = 5'h15; m_div = 32'd4;

        // RO and unmapped accesses
        wr(12'h000, 32'h12345678, 4'hF, 0, r);
        chk("wr_id_slverr", r, 2'b10);
        wr(12'h01C, 32'h12345678, 4'hF, 0, r);
        chk("wr_unmapped_slverr", r, 2'b10);
        rd(12'h000, d, r);
        chk("id_unchanged", d, 32'hACE0_0215);
        rd(12'h018, d, r);
        chk("rd_unmapped", {r, d}, {2'b10, 32'h0});
        wr(12'h010, 32'h1, 4'hF, 0, r);
        chk("wr_cnt_slverr", r, 2'b10);
`ifndef AXIL_LED_REGS_CNT_EN
        rd(12'h010, d, r);
        chk("cnt_lo_absent", {r, d}, {2'b00, 32'h0});
        rd(12'h014, d, r);
        chk("cnt_hi_absent", {r, d}, {2'b00, 32'h0});
`endif

        // backpressure: responses held, no new accepts
        write_req(12'h004, 32'h11112222, 4'hF, 0);
        m_scratch = 32'h11112222;
        bus.s_awaddr = 12'h004; bus.s_wdata = 32'h99999999; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        bus.s_araddr = 12'h000; bus.s_arvalid = 1'b1;
        read_req(12'h000);
        bus.s_araddr = 12'h004; bus.s_arvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge aclk); #1;
            chk("stall_b", {bus.s_bvalid, bus.s_bresp, bus.s_awready}, {1'b1, 2'b00, 1'b0});
            chk("stall_r", {bus.s_rvalid, bus.s_rdata, bus.s_arready}, {1'b1, 32'hACE0_0215, 1'b0});
        end
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        get_b(r);
        get_r(d, r);
        rd(12'h004, d, r);
        chk("stall_no_accept", d, 32'h11112222);

        // simultaneous read and write to the same register
        fork
            write_req(12'h004, 32'hCAFEF00D, 4'hF, 0);
            read_req(12'h004);
        join
        get_b(r);
        get_r(d, r);
        chk("same_cycle_pre_write", d, 32'h11112222);
        m_scratch = 32'hCAFEF00D;

`ifdef AXIL_LED_REGS_CNT_EN
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
        @(posedge aclk); #1;
        release dut.cnt_q;
        rd(12'h010, d, r);
        repeat (5) @(posedge aclk);
        #1;
        rd(12'h014, d2, xr);
        chk("cnt_resp", {r, xr}, 4'h0);
        chk("cnt_window", ({d2, d} - 64'h0000_0000_FFFF_FFFE) < 64'd64, 1'b1);
        chk("cnt_atomic", d2, (d < 32'h8000_0000) ? 32'h1 : 32'h0);
        rd(12'h014, xd, xr);
        chk("cnt_hi_stable", xd, d2);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            a  = 12'($urandom);
            a2 = 12'($urandom);
            d  = $urandom;
            st = 4'($urandom);
            if (op == 0) begin
                m_write(a, d, st, wr_exp);
                wr(a, d, st, $urandom_range(0, 1), r);
                chk("rnd_bresp", r, wr_exp);
            end else if (op == 1) begin
                m_read(a, xd, xr, known);
                rd(a, d2, r);
                chk("rnd_rresp", r, xr);
                if (known) chk("rnd_rdata", d2, xd);
            end else begin
                m_read(a2, xd, xr, known);
                m_write(a, d, st, wr_exp);
                fork
                    write_req(a, d, st, 0);
                    read_req(a2);
                join
                get_b(r);
                chk("rnd_dual_bresp", r, wr_exp);
                get_r(d2, r);
                chk("rnd_dual_rresp", r, xr);
                if (known) chk("rnd_dual_rdata", d2, xd);
            end
        end

        // reset with a write response pending drops it and clears registers
        write_req(12'h004, 32'h5A5A5A5A, 4'hF, 0);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        m_reset();
        chk("mid_rst_bvalid", bus.s_bvalid, 1'b0);
        chk("mid_rst_ledn", LEDn, 4'hF);
        rd(12'h004, d, r);
        chk("mid_rst_scratch", d, m_scratch);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
